// File: rtl/br_fifo_shared_pstatic_config_ctrl_if.sv
// Configuration interface of the shared pseudo-static multi-FIFO.
// The requester/datapath side uses the master modport; the sequencer uses the slave modport.
interface br_fifo_shared_pstatic_config_ctrl_if #(
   parameter int NumFifos = 2,
   parameter int Depth    = 3
);
   localparam int CountWidth = $clog2(Depth + 1);
   localparam int AddrWidth  = ($clog2(Depth) < 1) ? 1 : $clog2(Depth);

   logic                             cfg_req_valid;
   logic                             cfg_req_ready;
   logic [NumFifos*CountWidth-1:0]   cfg_req_size;
   logic [NumFifos-1:0]              fifo_empty;
   logic                             datapath_hold;
   logic                             config_valid;
   logic                             config_error;
   logic [NumFifos*CountWidth-1:0]   config_size;
   logic [NumFifos*AddrWidth-1:0]    config_base;
   logic [NumFifos*AddrWidth-1:0]    config_bound;
   logic [NumFifos*CountWidth-1:0]   credit_initial;

   modport master (
      output cfg_req_valid, cfg_req_size, fifo_empty,
      input  cfg_req_ready, datapath_hold, config_valid, config_error,
             config_size, config_base, config_bound, credit_initial
   );

   modport slave (
      input  cfg_req_valid, cfg_req_size, fifo_empty,
      output cfg_req_ready, datapath_hold, config_valid, config_error,
             config_size, config_base, config_bound, credit_initial
   );
endinterface

// File: rtl/br_fifo_shared_pstatic_config_ctrl.sv
// Runtime configuration sequencer for the shared pseudo-static multi-FIFO.
// Accepts a per-FIFO size vector, quiesces the datapath, waits for every FIFO
// to drain, lays the regions out back-to-back one FIFO per cycle, then commits
// the new layout atomically or rejects it and keeps the previous one.
module br_fifo_shared_pstatic_config_ctrl #(
   parameter int NumFifos = 2,
   parameter int Depth    = 3
) (
   input logic                               clk,
   input logic                               rst_n,
   br_fifo_shared_pstatic_config_ctrl_if.slave cfg
);
   localparam int AddrWidth   = ($clog2(Depth) < 1) ? 1 : $clog2(Depth);
   localparam int CountWidth  = $clog2(Depth + 1);
   localparam int IdxWidth    = ($clog2(NumFifos) < 1) ? 1 : $clog2(NumFifos);
   localparam int AccWidth    = CountWidth + 1;
   localparam int SizePerFifo = Depth / NumFifos;
   localparam int Remainder   = Depth % NumFifos;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumFifos - 1);

   if (NumFifos < 1 || Depth < NumFifos) begin : g_bad_params
      $error("br_fifo_shared_pstatic_config_ctrl: need NumFifos >= 1 and Depth >= NumFifos");
   end

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_DRAIN,
      ST_COMPUTE,
      ST_CHECK
   } state_t;

   // Even-split reset layout; the last FIFO absorbs the remainder.
   function automatic int default_size(int i);
      return (i == NumFifos - 1) ? SizePerFifo + Remainder : SizePerFifo;
   endfunction

   state_t state_q, next_state;

   logic [IdxWidth-1:0]                    idx_q;
   logic [AccWidth-1:0]                    acc_q;
   logic                                   err_q;
   logic [NumFifos-1:0][CountWidth-1:0]    shadow_size;
   logic [NumFifos-1:0][AddrWidth-1:0]     shadow_base;
   logic [NumFifos-1:0][AddrWidth-1:0]     shadow_bound;

   logic                                   ready_q;
   logic                                   hold_q;
   logic                                   valid_q;
   logic                                   error_q;
   logic [NumFifos-1:0][CountWidth-1:0]    size_q;
   logic [NumFifos-1:0][AddrWidth-1:0]     base_q;
   logic [NumFifos-1:0][AddrWidth-1:0]     bound_q;

   logic                                   accept;
   logic                                   all_empty;
   logic [CountWidth-1:0]                  cur_size;
   logic [AccWidth-1:0]                    sum_full;
   logic [AccWidth-1:0]                    acc_next;
   logic                                   step_err;

   assign accept    = cfg.cfg_req_valid && ready_q;
   assign all_empty = &cfg.fifo_empty;

   // Layout arithmetic for the FIFO currently being placed.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
      cur_size = shadow_size[idx_q];
      sum_full = acc_q + AccWidth'(cur_size);
      acc_next = sum_full;
      if (sum_full > AccWidth'(Depth + 1)) acc_next = AccWidth'(Depth + 1);
      step_err = (cur_size == '0) || (sum_full > AccWidth'(Depth));
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state_q <= ST_ACTIVE;
      else        state_q <= next_state;
   end

   // Next-state decode.
   always_comb begin
      next_state = state_q;
      unique case (state_q)
         ST_ACTIVE:  if (accept)           next_state = ST_DRAIN;
         ST_DRAIN:   if (all_empty)        next_state = ST_COMPUTE;
         ST_COMPUTE: if (idx_q == LastIdx) next_state = ST_CHECK;
         ST_CHECK:                         next_state = ST_ACTIVE;
         default:                          next_state = ST_ACTIVE;
      endcase
   end

   // Shadow layout, committed layout and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shadow registers are fully rewritten before use but are still reset, so the
         // layout path never carries X and an abandoned request leaves no trace.
         idx_q        <= '0;
         acc_q        <= '0;
         err_q        <= 1'b0;
         shadow_size  <= '0;
         shadow_base  <= '0;
         shadow_bound <= '0;
         ready_q      <= 1'b1;
         hold_q       <= 1'b0;
         valid_q      <= 1'b1;
         error_q      <= 1'b0;
         for (int i = 0; i < NumFifos; i++) begin
            size_q[i]  <= CountWidth'(default_size(i));
            base_q[i]  <= AddrWidth'(i * SizePerFifo);
            bound_q[i] <= AddrWidth'(i * SizePerFifo + default_size(i) - 1);
         end
      end else begin
         unique case (state_q)
            ST_ACTIVE: begin
               if (accept) begin
                  shadow_size <= cfg.cfg_req_size;
                  hold_q      <= 1'b1;
                  valid_q     <= 1'b0;
                  error_q     <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (all_empty) begin
                  idx_q <= '0;
                  acc_q <= '0;
                  err_q <= 1'b0;
               end
            end
            ST_COMPUTE: begin
               shadow_base[idx_q]  <= AddrWidth'(acc_q);
               shadow_bound[idx_q] <= AddrWidth'(sum_full - AccWidth'(1));
               err_q               <= err_q | step_err;
               acc_q               <= acc_next;
               if (idx_q != LastIdx) idx_q <= idx_q + IdxWidth'(1);
            end
            ST_CHECK: begin
               if (!err_q) begin
                  size_q  <= shadow_size;
                  base_q  <= shadow_base;
                  bound_q <= shadow_bound;
               end else begin
                  error_q <= 1'b1;
               end
               valid_q <= 1'b1;
               hold_q  <= 1'b0;
            end
            default: ;
         endcase
         ready_q <= (next_state == ST_ACTIVE);
      end
   end

   assign cfg.cfg_req_ready  = ready_q;
   assign cfg.datapath_hold  = hold_q;
   assign cfg.config_valid   = valid_q;
   assign cfg.config_error   = error_q;
   assign cfg.config_size    = size_q;
   assign cfg.config_base    = base_q;
   assign cfg.config_bound   = bound_q;
   assign cfg.credit_initial = size_q;

   // A committed config never coexists with a held datapath.
   a_valid_not_hold: assert property (@(posedge clk) disable iff (!rst_n) valid_q |-> !hold_q);

   // The datapath is quiesced right after a request is taken.
   a_hold_after_accept: assert property (@(posedge clk) disable iff (!rst_n) accept |=> hold_q);

   // A committed layout is frozen while it is in force.
   a_config_stable: assert property (@(posedge clk) disable iff (!rst_n)
      valid_q |=> ($stable(size_q) && $stable(base_q) && $stable(bound_q)));

   // Committed regions are ordered, non-overlapping and inside the RAM.
   for (genvar g = 0; g < NumFifos; g++) begin : g_region_chk
      a_bound_in_ram: assert property (@(posedge clk) disable iff (!rst_n)
         valid_q |-> (int'(bound_q[g]) < Depth && base_q[g] <= bound_q[g]));
      if (g < NumFifos - 1) begin : g_next
         a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
            valid_q |-> (bound_q[g] < base_q[g+1]));
      end
   end
endmodule

// File: tb/tb_br_fifo_shared_pstatic_config_ctrl.sv
// Self-checking bench for the shared multi-FIFO configuration sequencer.
// Directed and randomized requests are compared against a layout model that
// works purely from prefix sums of the requested sizes.
module tb_br_fifo_shared_pstatic_config_ctrl;
   localparam int N   = 2;
   localparam int D   = 8;
   localparam int CW  = 4;
   localparam int AW  = 3;
   localparam int CW3 = 2;
   localparam int AW3 = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   br_fifo_shared_pstatic_config_ctrl_if #(.NumFifos(N), .Depth(D)) bus ();
   br_fifo_shared_pstatic_config_ctrl_if #(.NumFifos(2), .Depth(3)) bus3 ();

   br_fifo_shared_pstatic_config_ctrl #(.NumFifos(N), .Depth(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (bus)
   );

   br_fifo_shared_pstatic_config_ctrl #(.NumFifos(2), .Depth(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (bus3)
   );

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: the layout currently in force and the sticky error.
   int m_size  [N];
   int m_base  [N];
   int m_bound [N];
   bit m_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      int acc = 0;
      for (int i = 0; i < N; i++) begin
         m_size[i]  = (i == N - 1) ? D / N + D % N : D / N;
         m_base[i]  = acc;
         m_bound[i] = acc + m_size[i] - 1;
         acc += m_size[i];
      end
      m_err = 1'b0;
   endfunction

   // A request is legal when no size is zero and the sizes fit in the RAM.
   function automatic void model_apply(input int s0, input int s1);
      int req [N];
      int sum = 0;
      bit ok  = 1'b1;
      req[0] = s0;
      req[1] = s1;
      for (int i = 0; i < N; i++) begin
         if (req[i] == 0) ok = 1'b0;
         sum += req[i];
      end
      if (sum > D) ok = 1'b0;
      if (ok) begin
         sum = 0;
         for (int i = 0; i < N; i++) begin
            m_size[i]  = req[i];
            m_base[i]  = sum;
            m_bound[i] = sum + req[i] - 1;
            sum += req[i];
         end
      end
      m_err = !ok;
   endfunction

   task automatic check_layout(input string tag);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s size[%0d]", tag, i), 64'(bus.config_size[i*CW +: CW]), 64'(m_size[i]));
         chk($sformatf("%s credit[%0d]", tag, i), 64'(bus.credit_initial[i*CW +: CW]), 64'(m_size[i]));
         chk($sformatf("%s base[%0d]", tag, i), 64'(bus.config_base[i*AW +: AW]), 64'(m_base[i]));
         chk($sformatf("%s bound[%0d]", tag, i), 64'(bus.config_bound[i*AW +: AW]), 64'(m_bound[i]));
      end
   endtask

   task automatic check_status(input string tag, input bit valid, input bit hold, input bit ready);
      chk({tag, " config_valid"}, 64'(bus.config_valid), 64'(valid));
      chk({tag, " datapath_hold"}, 64'(bus.datapath_hold), 64'(hold));
      chk({tag, " cfg_req_ready"}, 64'(bus.cfg_req_ready), 64'(ready));
   endtask

   // Issue one request; the FIFOs report non-empty for drain_cycles cycles first.
   task automatic do_request(input int s0, input int s1, input int drain_cycles, input string tag);
      int k = 0;
      while (!bus.cfg_req_ready && k < 20) begin
         step();
         k++;
      end
      chk({tag, " ready before request"}, 64'(bus.cfg_req_ready), 64'd1);
      bus.cfg_req_size[0 +: CW]  = CW'(s0);
      bus.cfg_req_size[CW +: CW] = CW'(s1);
      bus.cfg_req_valid          = 1'b1;
      bus.fifo_empty             = (drain_cycles > 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      step();
      bus.cfg_req_valid = 1'b0;
      bus.cfg_req_size  = 8'($urandom);
      check_status({tag, " cycle1"}, 1'b0, 1'b1, 1'b0);
      chk({tag, " cycle1 config_error"}, 64'(bus.config_error), 64'd0);
      for (int d = 0; d < drain_cycles; d++) begin
         step();
         check_status($sformatf("%s drain%0d", tag, d), 1'b0, 1'b1, 1'b0);
      end
      bus.fifo_empty = 2'b11;
      repeat (3) step();
      check_status({tag, " check-cycle"}, 1'b0, 1'b1, 1'b0);
      check_layout({tag, " pre-commit"});
      step();
      model_apply(s0, s1);
      check_status({tag, " commit"}, 1'b1, 1'b0, 1'b1);
      chk({tag, " config_error"}, 64'(bus.config_error), 64'(m_err));
      check_layout({tag, " commit"});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin
      bus.cfg_req_valid  = 1'b0;
      bus.cfg_req_size   = '0;
      bus.fifo_empty     = 2'b11;
      bus3.cfg_req_valid = 1'b0;
      bus3.cfg_req_size  = '0;
      bus3.fifo_empty    = 2'b11;
      model_reset();

      // Reset state of both instances.
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();
      check_status("reset", 1'b1, 1'b0, 1'b1);
      chk("reset config_error", 64'(bus.config_error), 64'd0);
      check_layout("reset");
      chk("d3 size[0]", 64'(bus3.config_size[0 +: CW3]), 64'd1);
      chk("d3 size[1]", 64'(bus3.config_size[CW3 +: CW3]), 64'd2);
      chk("d3 base[0]", 64'(bus3.config_base[0 +: AW3]), 64'd0);
      chk("d3 base[1]", 64'(bus3.config_base[AW3 +: AW3]), 64'd1);
      chk("d3 bound[0]", 64'(bus3.config_bound[0 +: AW3]), 64'd0);
      chk("d3 bound[1]", 64'(bus3.config_bound[AW3 +: AW3]), 64'd2);
      chk("d3 config_valid", 64'(bus3.config_valid), 64'd1);

      // Idle cycles without a request leave the layout alone.
      repeat (3) step();
      check_layout("idle");

      // Directed layouts, rejects and recovery.
      do_request(3, 5, 0, "req35");
      do_request(6, 3, 0, "req63_over");
      do_request(0, 4, 0, "req04_zero");
      do_request(2, 2, 0, "req22");
      do_request(4, 4, 10, "req44_drain");
      do_request(1, 7, 0, "req17_exact");
      do_request(7, 2, 2, "req72_over");
      do_request(1, 1, 1, "req11_under");

      // Randomized requests, including zero sizes and oversubscription.
      for (int t = 0; t < 25; t++) begin
         do_request(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
      end

      // Asynchronous reset while laying out a request.
      do_request(2, 2, 0, "pre_reset");
      bus.cfg_req_size[0 +: CW]  = CW'(3);
      bus.cfg_req_size[CW +: CW] = CW'(5);
      bus.cfg_req_valid          = 1'b1;
      bus.fifo_empty             = 2'b11;
      step();
      bus.cfg_req_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_status("async reset", 1'b1, 1'b0, 1'b1);
      chk("async reset config_error", 64'(bus.config_error), 64'd0);
      check_layout("async reset");
      repeat (2) step();
      #3;
      rst_n = 1'b1;
      repeat (6) step();
      check_status("after reset", 1'b1, 1'b0, 1'b1);
      check_layout("after reset");

      // Normal operation resumes after the reset.
      do_request(5, 3, 0, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
